// File: rtl/cart_loader.sv
// cart_loader: packs 16-bit HPS download beats into 32-bit SDRAM write requests.
// Define CART_BYTEORDER_DETECT_EN to build .z64/.v64/.n64 header detection; otherwise words pass through in z64 order.
//
// state | meaning
// IDLE  | waiting for a download to start
// FILL  | collecting the halves of the current word
// ISSUE | write outstanding, HPS stalled until mem_ready
// DONE  | download finished, cart_loaded raised
module cart_loader #(
    parameter int CART_BASE = 1048576,
    parameter int ADDR_W    = 27
) (
    input  logic              clk1x_i,
    input  logic              reset_n_i,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [15:0]       dl_data_i,
    output logic              dl_wait_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ready_i,
    output logic [1:0]        cart_fmt_o,
    output logic [ADDR_W-1:0] cart_size_o,
    output logic              cart_loaded_o,
    output logic              proto_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_DONE} state_t;
    localparam int WA_W = ADDR_W - 2;

    state_t            state_q, state_d;
    logic              act_q;
    logic [15:0]       lo_q, lo_d;
    logic              lo_vld_q, lo_vld_d;
    logic [WA_W-1:0]   pend_wa_q, pend_wa_d;
    logic              held_vld_q, held_vld_d;
    logic [ADDR_W-2:0] held_addr_q, held_addr_d;
    logic [15:0]       held_data_q, held_data_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] size_q, size_d;
    logic              loaded_q, loaded_d;
    logic              perr_q, perr_d;

    logic              act_rise;
    logic              dl_wait;
    logic              beat_vld;
    logic [ADDR_W-2:0] beat_addr;
    logic [15:0]       beat_data;
    logic              issue_go;
    logic [WA_W-1:0]   issue_wa;
    logic [31:0]       issue_word;
    logic [ADDR_W-1:0] issue_size;

    // Beats are always half-word aligned, so the byte-select bit carries no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = dl_addr_i[0];

`ifdef CART_BYTEORDER_DETECT_EN
    logic [1:0] fmt_q, fmt_d;
    logic       fmt_done_q, fmt_done_d;
    logic [1:0] issue_fmt;

    // Word argument is {b3, b2, b1, b0} in file order.
    function automatic logic [1:0] detect_fmt(input logic [31:0] w);
        case (w)
            32'h4012_3780: detect_fmt = 2'd0;
            32'h1240_8037: detect_fmt = 2'd1;
            32'h8037_1240: detect_fmt = 2'd2;
            default:       detect_fmt = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] swap_word(input logic [1:0] fmt, input logic [31:0] w);
        case (fmt)
            2'd1:    swap_word = {w[23:16], w[31:24], w[7:0], w[15:8]};
            2'd2:    swap_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
            default: swap_word = w;
        endcase
    endfunction

    assign cart_fmt_o = fmt_q;
`else
    assign cart_fmt_o = 2'd0;
`endif

    assign act_rise = dl_active_i & ~act_q;
    // A held beat still needs a FILL cycle of its own, so the HPS stays stalled for it.
    assign dl_wait  = (state_q == S_ISSUE) | held_vld_q;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        lo_vld_d    = lo_vld_q;
        pend_wa_d   = pend_wa_q;
        held_vld_d  = held_vld_q;
        held_addr_d = held_addr_q;
        held_data_d = held_data_q;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        size_d      = size_q;
        loaded_d    = loaded_q;
        perr_d      = perr_q | (dl_wr_i & dl_wait);
        beat_vld    = 1'b0;
        beat_addr   = '0;
        beat_data   = '0;
        issue_go    = 1'b0;
        issue_wa    = '0;
        issue_word  = '0;
        issue_size  = '0;
`ifdef CART_BYTEORDER_DETECT_EN
        fmt_d      = fmt_q;
        fmt_done_d = fmt_done_q;
        issue_fmt  = fmt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (act_rise) begin
                    loaded_d   = 1'b0;
                    size_d     = '0;
                    perr_d     = 1'b0;
                    lo_vld_d   = 1'b0;
                    held_vld_d = 1'b0;
`ifdef CART_BYTEORDER_DETECT_EN
                    fmt_d      = 2'd0;
                    fmt_done_d = 1'b0;
`endif
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (held_vld_q) begin
                    beat_vld   = 1'b1;
                    beat_addr  = held_addr_q;
                    beat_data  = held_data_q;
                    held_vld_d = 1'b0;
                end else if (!dl_active_i) begin
                    if (lo_vld_q) begin
                        issue_go   = 1'b1;
                        issue_wa   = pend_wa_q;
                        issue_word = {16'h0000, lo_q};
                    end else begin
                        state_d  = S_DONE;
                        loaded_d = 1'b1;
                    end
                end else if (dl_wr_i) begin
                    beat_vld  = 1'b1;
                    beat_addr = dl_addr_i[ADDR_W-1:1];
                    beat_data = dl_data_i;
                end

                if (beat_vld) begin
                    if (lo_vld_q && (beat_addr[ADDR_W-2:1] != pend_wa_q)) begin
                        issue_go    = 1'b1;
                        issue_wa    = pend_wa_q;
                        issue_word  = {16'h0000, lo_q};
                        held_vld_d  = 1'b1;
                        held_addr_d = beat_addr;
                        held_data_d = beat_data;
                    end else if (!beat_addr[0]) begin
                        lo_d      = beat_data;
                        lo_vld_d  = 1'b1;
                        pend_wa_d = beat_addr[ADDR_W-2:1];
                    end else begin
                        issue_go   = 1'b1;
                        issue_wa   = beat_addr[ADDR_W-2:1];
                        issue_word = {beat_data, (lo_vld_q ? lo_q : 16'h0000)};
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ready_i) begin
                    if (dl_active_i || held_vld_q) begin
                        state_d = S_FILL;
                    end else begin
                        state_d  = S_DONE;
                        loaded_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue_go) begin
            state_d    = S_ISSUE;
            mem_req_d  = 1'b1;
            lo_vld_d   = 1'b0;
            mem_addr_d = ADDR_W'(CART_BASE) + {issue_wa, 2'b00};
            issue_size = {issue_wa, 2'b00} + ADDR_W'(4);
            if (issue_size > size_q) begin
                size_d = issue_size;
            end
`ifdef CART_BYTEORDER_DETECT_EN
            if (!fmt_done_q && (issue_wa == '0)) begin
                issue_fmt  = detect_fmt(issue_word);
                fmt_d      = issue_fmt;
                fmt_done_d = 1'b1;
            end
            mem_data_d = swap_word(issue_fmt, issue_word);
`else
            mem_data_d = issue_word;
`endif
        end
    end

    always_ff @(posedge clk1x_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            act_q       <= 1'b0;
            lo_q        <= '0;
            lo_vld_q    <= 1'b0;
            pend_wa_q   <= '0;
            held_vld_q  <= 1'b0;
            held_addr_q <= '0;
            held_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            size_q      <= '0;
            loaded_q    <= 1'b0;
            perr_q      <= 1'b0;
`ifdef CART_BYTEORDER_DETECT_EN
            fmt_q       <= 2'd0;
            fmt_done_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            act_q       <= dl_active_i;
            lo_q        <= lo_d;
            lo_vld_q    <= lo_vld_d;
            pend_wa_q   <= pend_wa_d;
            held_vld_q  <= held_vld_d;
            held_addr_q <= held_addr_d;
            held_data_q <= held_data_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            size_q      <= size_d;
            loaded_q    <= loaded_d;
            perr_q      <= perr_d;
`ifdef CART_BYTEORDER_DETECT_EN
            fmt_q       <= fmt_d;
            fmt_done_q  <= fmt_done_d;
`endif
        end
    end

    assign dl_wait_o     = dl_wait;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign cart_size_o   = size_q;
    assign cart_loaded_o = loaded_q;
    assign proto_err_o   = perr_q;

endmodule

// File: tb/tb_cart_loader.sv
// Testbench for cart_loader: HPS beat driver, randomised SDRAM responder and a file-level reference model.
// Expected byte order follows CART_BYTEORDER_DETECT_EN, matching the build of the design.
module tb_cart_loader;
    localparam int ADDR_W    = 27;
    localparam int CART_BASE = 1048576;
    localparam int NB        = 64;

`ifdef CART_BYTEORDER_DETECT_EN
    localparam logic [31:0] V64_W0  = 32'h4012_3780;
    localparam logic [31:0] V64_W1  = 32'h3344_1122;
    localparam logic [31:0] N64_W0  = 32'h4012_3780;
    localparam logic [1:0]  V64_FMT = 2'd1;
    localparam logic [1:0]  N64_FMT = 2'd2;
`else
    localparam logic [31:0] V64_W0  = 32'h1240_8037;
    localparam logic [31:0] V64_W1  = 32'h4433_2211;
    localparam logic [31:0] N64_W0  = 32'h8037_1240;
    localparam logic [1:0]  V64_FMT = 2'd0;
    localparam logic [1:0]  N64_FMT = 2'd0;
`endif

    logic              clk_sys   = 1'b0;
    logic              rst_b     = 1'b0;
    logic              dl_active = 1'b0;
    logic              dl_wr     = 1'b0;
    logic [ADDR_W-1:0] dl_addr   = '0;
    logic [15:0]       dl_data   = '0;
    logic              mem_ready = 1'b0;
    logic              dl_wait;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic [1:0]        cart_fmt;
    logic [ADDR_W-1:0] cart_size;
    logic              cart_loaded;
    logic              proto_err;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_delay = -1;

    logic [15:0] beat_val [NB];
    bit          beat_sent[NB];
    int          nbeats;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [1:0]        got_fmt[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [1:0]        efmt;
    int                esize;

    cart_loader #(.CART_BASE(CART_BASE), .ADDR_W(ADDR_W)) u_dut (
        .clk1x_i      (clk_sys),
        .reset_n_i    (rst_b),
        .dl_active_i  (dl_active),
        .dl_wr_i      (dl_wr),
        .dl_addr_i    (dl_addr),
        .dl_data_i    (dl_data),
        .dl_wait_o    (dl_wait),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_data),
        .mem_ready_i  (mem_ready),
        .cart_fmt_o   (cart_fmt),
        .cart_size_o  (cart_size),
        .cart_loaded_o(cart_loaded),
        .proto_err_o  (proto_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // SDRAM side: one mem_ready pulse per request, 0..3 cycles late unless rdy_delay pins it.
    bit rsp_busy = 1'b0;
    int rsp_cnt  = 0;
    always begin
        @(posedge clk_sys);
        #1;
        mem_ready = 1'b0;
        if (mem_req) begin
            rsp_busy = 1'b1;
            rsp_cnt  = (rdy_delay < 0) ? int'($urandom_range(0, 3)) : rdy_delay;
        end
        if (rsp_busy) begin
            if (rsp_cnt == 0) begin
                mem_ready = 1'b1;
                rsp_busy  = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
    end

    bit                out_q = 1'b0;
    logic [ADDR_W-1:0] hold_addr;
    logic [31:0]       hold_data;
    always @(negedge clk_sys) begin
        if (!rst_b) begin
            out_q = 1'b0;
        end else begin
            if (mem_req) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_data);
                got_fmt.push_back(cart_fmt);
                out_q     = 1'b1;
                hold_addr = mem_addr;
                hold_data = mem_data;
            end else if (out_q) begin
                check_val("hold_addr", mem_addr, hold_addr);
                check_val("hold_data", mem_data, hold_data);
            end
            if (mem_ready) out_q = 1'b0;
        end
    end

    // File-level model: every word with at least one half sent becomes one write, missing halves read as zero.
    function automatic void build_expect();
        bit          lo_s, hi_s;
        logic [15:0] lo, hi;
        logic [7:0]  b[4];
        int          p[4];
        exp_addr.delete();
        exp_data.delete();
        efmt  = 2'd0;
        esize = 0;
        for (int w = 0; w < (nbeats + 1) / 2; w++) begin
            lo_s = beat_sent[2*w];
            hi_s = (2*w + 1 < nbeats) && beat_sent[2*w + 1];
            if (!lo_s && !hi_s) continue;
            lo = lo_s ? beat_val[2*w] : 16'h0000;
            hi = hi_s ? beat_val[2*w + 1] : 16'h0000;
            b[0] = lo[7:0];
            b[1] = lo[15:8];
            b[2] = hi[7:0];
            b[3] = hi[15:8];
`ifdef CART_BYTEORDER_DETECT_EN
            if (w == 0) begin
                if (b[0] == 8'h80 && b[1] == 8'h37 && b[2] == 8'h12 && b[3] == 8'h40) efmt = 2'd0;
                else if (b[0] == 8'h37 && b[1] == 8'h80 && b[2] == 8'h40 && b[3] == 8'h12) efmt = 2'd1;
                else if (b[0] == 8'h40 && b[1] == 8'h12 && b[2] == 8'h37 && b[3] == 8'h80) efmt = 2'd2;
                else efmt = 2'd3;
            end
`endif
            case (efmt)
                2'd1:    p = '{1, 0, 3, 2};
                2'd2:    p = '{3, 2, 1, 0};
                default: p = '{0, 1, 2, 3};
            endcase
            exp_data.push_back({b[p[3]], b[p[2]], b[p[1]], b[p[0]]});
            exp_addr.push_back(ADDR_W'(CART_BASE + 4 * w));
            esize = (w + 1) * 4;
        end
    endfunction

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_wait"},   dl_wait, 0);
        check_val({tag, "_req"},    mem_req, 0);
        check_val({tag, "_addr"},   mem_addr, 0);
        check_val({tag, "_data"},   mem_data, 0);
        check_val({tag, "_fmt"},    cart_fmt, 0);
        check_val({tag, "_size"},   cart_size, 0);
        check_val({tag, "_loaded"}, cart_loaded, 0);
        check_val({tag, "_perr"},   proto_err, 0);
    endtask

    task automatic send_beat(input int addr, input logic [15:0] data);
        int guard = 0;
        while (dl_wait && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check_val("dl_wait_stuck", dl_wait, 0);
        dl_wr   = 1'b1;
        dl_addr = ADDR_W'(addr);
        dl_data = data;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic start_download();
        got_addr.delete();
        got_data.delete();
        got_fmt.delete();
        dl_active = 1'b1;
        tick();
    endtask

    task automatic send_beats(input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            if (beat_sent[b]) begin
                if (gaps) repeat ($urandom_range(0, 2)) tick();
                send_beat(2 * b, beat_val[b]);
            end
        end
    endtask

    task automatic finish_download(input string tag, input bit drop_early, input bit exp_perr);
        int guard = 0;
        if (!drop_early) begin
            while (dl_wait && guard < 100) begin
                tick();
                guard++;
            end
        end
        dl_active = 1'b0;
        guard = 0;
        while (!cart_loaded && guard < 100) begin
            tick();
            guard++;
        end
        check_val({tag, "_loaded"}, cart_loaded, 1);
        build_expect();
        check_val({tag, "_nreq"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check_val($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check_val($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
        if (got_fmt.size() > 0) check_val({tag, "_fmt_first"}, got_fmt[0], efmt);
        check_val({tag, "_fmt"},  cart_fmt, efmt);
        check_val({tag, "_size"}, cart_size, esize);
        check_val({tag, "_perr"}, proto_err, exp_perr);
        tick();
        tick();
    endtask

    task automatic set_beats(input int n, input logic [15:0] v0, input logic [15:0] v1,
                             input logic [15:0] v2, input logic [15:0] v3);
        nbeats = n;
        for (int b = 0; b < NB; b++) begin
            beat_sent[b] = 1'b1;
            beat_val[b]  = 16'h0000;
        end
        beat_val[0] = v0;
        beat_val[1] = v1;
        beat_val[2] = v2;
        beat_val[3] = v3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_reset_vals("rst");
        rst_b = 1'b1;
        tick();

        // z64 header with request latency and release timing
        rdy_delay = 2;
        set_beats(2, 16'h3780, 16'h4012, 16'h0, 16'h0);
        start_download();
        send_beat(0, 16'h3780);
        send_beat(2, 16'h4012);
        check_val("z64_req",  mem_req, 1);
        check_val("z64_addr", mem_addr, 32'h0010_0000);
        check_val("z64_data", mem_data, 32'h4012_3780);
        check_val("z64_fmt",  cart_fmt, 0);
        check_val("z64_wait", dl_wait, 1);
        tick();
        check_val("z64_req_pulse", mem_req, 0);
        tick();
        check_val("z64_wait_held", dl_wait, 1);
        tick();
        check_val("z64_wait_rel", dl_wait, 0);
        finish_download("z64", 1'b0, 1'b0);

        // v64 header followed by a second word
        rdy_delay = -1;
        set_beats(4, 16'h8037, 16'h1240, 16'h2211, 16'h4433);
        start_download();
        send_beats(1'b0);
        finish_download("v64", 1'b0, 1'b0);
        if (got_data.size() > 1) begin
            check_val("v64_w0", got_data[0], V64_W0);
            check_val("v64_w1", got_data[1], V64_W1);
        end
        check_val("v64_fmt_c", cart_fmt, V64_FMT);

        set_beats(2, 16'h1240, 16'h8037, 16'h0, 16'h0);
        start_download();
        send_beats(1'b0);
        finish_download("n64", 1'b0, 1'b0);
        if (got_data.size() > 0) check_val("n64_w0", got_data[0], N64_W0);
        check_val("n64_fmt_c", cart_fmt, N64_FMT);

        // 6-byte file: trailing low half flushed on dl_active fall
        rdy_delay = 0;
        set_beats(3, 16'h3780, 16'h4012, 16'hBBAA, 16'h0);
        start_download();
        send_beats(1'b0);
        check_val("odd_wait", dl_wait, 0);
        dl_active = 1'b0;
        tick();
        check_val("odd_flush_req",  mem_req, 1);
        check_val("odd_flush_addr", mem_addr, 32'h0010_0004);
        check_val("odd_flush_data", mem_data, 32'h0000_BBAA);
        tick();
        check_val("odd_loaded", cart_loaded, 1);
        check_val("odd_size_c", cart_size, 8);
        finish_download("odd", 1'b1, 1'b0);

        // beat injected while stalled is dropped and flagged
        rdy_delay = 10;
        set_beats(2, 16'h3780, 16'h4012, 16'h0, 16'h0);
        start_download();
        send_beats(1'b0);
        tick();
        tick();
        check_val("perr_wait", dl_wait, 1);
        dl_wr   = 1'b1;
        dl_addr = ADDR_W'(4);
        dl_data = 16'hDEAD;
        tick();
        dl_wr   = 1'b0;
        check_val("perr_flag", proto_err, 1);
        finish_download("perr", 1'b0, 1'b1);

        // reset while a write is outstanding; the late mem_ready must be ignored
        set_beats(2, 16'h3780, 16'h4012, 16'h0, 16'h0);
        start_download();
        send_beats(1'b0);
        tick();
        tick();
        rst_b     = 1'b0;
        dl_active = 1'b0;
        tick();
        tick();
        check_reset_vals("midrst");
        rst_b = 1'b1;
        got_addr.delete();
        got_data.delete();
        got_fmt.delete();
        repeat (15) tick();
        check_val("midrst_late_loaded", cart_loaded, 0);
        check_val("midrst_late_req", got_addr.size(), 0);
        rdy_delay = -1;
        set_beats(4, 16'h3780, 16'h4012, 16'h5566, 16'h7788);
        start_download();
        send_beats(1'b1);
        finish_download("after_rst", 1'b0, 1'b0);

        // randomised files with holes, random headers, gaps and fall timing
        for (int it = 0; it < 8; it++) begin
            int sel;
            nbeats = $urandom_range(2, 40);
            for (int b = 0; b < NB; b++) begin
                beat_val[b]  = 16'($urandom);
                beat_sent[b] = (b < 2) || ($urandom_range(0, 99) < 85);
            end
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin beat_val[0] = 16'h3780; beat_val[1] = 16'h4012; end
                1: begin beat_val[0] = 16'h8037; beat_val[1] = 16'h1240; end
                2: begin beat_val[0] = 16'h1240; beat_val[1] = 16'h8037; end
                default: ;
            endcase
            start_download();
            send_beats(1'b1);
            finish_download($sformatf("rnd%0d", it), ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cart_loader.md
# cart_loader

Packs the 16-bit HPS cartridge download stream into 32-bit words and normalises byte order (.z64/.v64/.n64) before issuing write requests to the SDRAM download channel. Sits between the HPS ioctl interface and SDRAM channel 2, and owns the ioctl wait handshake. Reports cartridge size, format and load status to the system core.

## Interface

**Parameters**
- `CART_BASE`, default 1048576: SDRAM byte offset of ROM byte 0.
- `ADDR_W`, default 27: byte address width.

**Ports**
- `clk1x`, in, 1: system clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `dl_active`, in, 1: cartridge download in progress (index already decoded).
- `dl_wr`, in, 1: one-cycle data strobe.
- `dl_addr`, in, ADDR_W: file byte address, always even.
- `dl_data`, in, 16: `[7:0]` = file byte at `dl_addr`; `[15:8]` = file byte at `dl_addr+1`.
- `dl_wait`, out, 1: stall request to the HPS.
- `mem_req`, out, 1: one-cycle write request.
- `mem_addr`, out, ADDR_W: SDRAM byte address, word aligned.
- `mem_data`, out, 32: `[7:0]` = ROM byte 4n, `[15:8]` = 4n+1, `[23:16]` = 4n+2, `[31:24]` = 4n+3.
- `mem_ready`, in, 1: one-cycle completion of the outstanding write.
- `cart_fmt`, out, 2: 0 = z64, 1 = v64, 2 = n64, 3 = unknown (handled as z64).
- `cart_size`, out, ADDR_W: ROM size in bytes, rounded up to a multiple of 4.
- `cart_loaded`, out, 1: a complete download has finished.
- `proto_err`, out, 1: sticky; set when `dl_wr` is received while `dl_wait` is high.

## Operation

**States:** IDLE, FILL, ISSUE, DONE.

- **IDLE:** on a `dl_active` rising edge:
  - clear `cart_loaded`, `cart_size`, `proto_err` and the half-valid flags;
  - go to FILL.
- **FILL:** a `dl_wr` beat with `dl_addr[1]=0` latches the low half. A beat with `dl_addr[1]=1` latches the high half. Word address = `dl_addr[ADDR_W-1:2]`.
  - When the high half is latched, build the word and go to ISSUE. Any half not received since the last issue is 0x0000.
  - A `dl_wr` with a different word address while a low half is pending first flushes the pending word (high half 0x0000). The new beat is then held and processed after that flush completes.
- **Format detect** (only when `CART_BYTEORDER_DETECT_EN` is defined): the first completed word at word address 0 is examined as file bytes b0..b3.
  - 80 37 12 40 gives z64.
  - 37 80 40 12 gives v64.
  - 40 12 37 80 gives n64.
  - Anything else gives unknown.
  - `cart_fmt` is latched and applied to that word and to every later word.
- **Swap** (file bytes b0..b3 to `mem_data` bytes 0..3):
  - z64 / unknown: b0 b1 b2 b3.
  - v64: b1 b0 b3 b2.
  - n64: b3 b2 b1 b0.
- **ISSUE:**
  - `mem_req` pulses once.
  - `mem_addr = CART_BASE + {word, 2'b00}`, truncated to ADDR_W.
  - `dl_wait` stays high until `mem_ready` arrives.
  - `cart_size` is updated to `max(cart_size, (word+1)*4)`.
  - After `mem_ready`: go to FILL, or to DONE if `dl_active` is low.
- **`dl_active` falls in FILL:**
  - With a low half pending: flush it (high half 0x0000) via ISSUE, then go to DONE.
  - Otherwise go straight to DONE.
- **`dl_active` falls in ISSUE:** the write completes normally, then DONE.
- **DONE:** set `cart_loaded`, go to IDLE.
- **`dl_wr` while `dl_wait` is high:** the beat is dropped and `proto_err` is set.
- **`reset_n` low:** all state is abandoned immediately, including an outstanding request. A `mem_ready` arriving afterwards is ignored.

## Timing

- **Reset values:** `dl_wait` 0, `mem_req` 0, `mem_addr` 0, `mem_data` 0, `cart_fmt` 0, `cart_size` 0, `cart_loaded` 0, `proto_err` 0.
- **Request latency:** the high-half `dl_wr` beat is at cycle N.
  - `mem_req`, `mem_addr` and `mem_data` are valid at N+1.
  - `dl_wait` is high from N+1.
- **Data hold:** `mem_addr` and `mem_data` stay stable from `mem_req` until `mem_ready`.
- **Release:** `mem_ready` at cycle M gives `dl_wait` low at M+1. The earliest next `mem_req` is M+2.
- **`mem_ready` timing:** `mem_ready` in the same cycle as `mem_req` is legal. It must not arrive earlier.
- **Flush on `dl_active` fall:** sampled at cycle F, flush `mem_req` at F+1.
- **`cart_loaded` timing:** rises the cycle after the last `mem_ready`, or at F+1 if nothing is pending.
- **Format decision timing:** `cart_fmt` is valid in the same cycle as the first `mem_req`.

## Configuration

- **`CART_BYTEORDER_DETECT_EN` defined:** header detection and swapping as described above.
- **Not defined:**
  - no detection logic is built;
  - `cart_fmt` is tied to 0;
  - all words pass through in z64 order.

## Test plan

- **z64 header:** beats (addr 0, 0x3780), (addr 2, 0x4012) → `mem_req` with `mem_addr`=0x100000, `mem_data`=0x40123780, `cart_fmt`=0.
- **v64 header:** beats (0, 0x8037), (2, 0x1240) → `mem_data`=0x40123780, `cart_fmt`=1. A following word with file bytes 11 22 33 44 gives `mem_data`=0x33441122.
- **n64 header:** beats (0, 0x1240), (2, 0x8037) → `mem_data`=0x40123780, `cart_fmt`=2.
- **Odd-length file:** a 6-byte file ends with (4, 0xBBAA), then `dl_active` falls → second `mem_req` at 0x100004 with `mem_data`=0x0000BBAA, then `cart_size`=8 and `cart_loaded`=1.
- **Protocol violation:** hold `mem_ready` off for 10 cycles and inject `dl_wr` during `dl_wait` → beat dropped, `proto_err`=1, no extra `mem_req`.
- **Reset mid-operation:** assert `reset_n` low while in ISSUE, then release → all outputs at reset values. A late `mem_ready` produces no `cart_loaded`. The next download restarts at word 0.
